// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter sharing one memory port between NUM_REQ requesters.
//   A grant is held for a whole transaction (accept -> issue -> wait -> done),
//   so only one memory access is ever outstanding. The registered grant index
//   o_sel steers the shared data-path muxes outside this block.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to enable the response
//   watchdog (TIMEOUT_CYCLES WAIT cycles without i_mem_rvalid -> error reply).
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/we [NUM_REQ]  per-requester request and write enable
//   i_req_addr/wdata          concatenated payloads, requester i at slice i
//   o_req_ready [NUM_REQ]     one-hot accept (combinational, IDLE only)
//   o_rsp_valid [NUM_REQ]     one-hot, one-cycle response pulse
//   o_rsp_rdata, o_rsp_err    shared response data, timeout flag
//   o_sel                     registered grant index
//   o_mem_*                   request to memory (valid/we/addr/wdata)
//   i_mem_ready               memory accepted the request
//   i_mem_rvalid, i_mem_rdata memory response / write acknowledge
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]    o_sel,
  output logic                          o_mem_valid,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  input  logic                          i_mem_ready,
  input  logic                          i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);

  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  logic [SEL_W-1:0]      r_rr_ptr;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_mem_valid;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Unpack the concatenated payload buses into per-requester arrays.
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_addr_arr[gi]  = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = i_req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester at or above r_rr_ptr, wrapping.
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  int               w_idx;
  always_comb begin
    w_winner = r_rr_ptr;
    w_any    = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && i_req_valid[SEL_W'(w_idx)]) begin
        w_winner = SEL_W'(w_idx);
        w_any    = 1'b1;
      end
    end
  end

  logic [SEL_W-1:0] w_rr_next;
  assign w_rr_next = (w_winner == SEL_W'(NUM_REQ-1)) ? '0 : w_winner + SEL_W'(1);

  always_comb begin
    o_req_ready = '0;
    if (r_state == S_IDLE && w_any) o_req_ready[w_winner] = 1'b1;
  end

  logic [NUM_REQ-1:0] w_sel_onehot;
  always_comb begin
    w_sel_onehot        = '0;
    w_sel_onehot[r_sel] = 1'b1;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counts WAIT cycles already spent; the timeout fires on the
  // TIMEOUT_CYCLES-th WAIT cycle unless i_mem_rvalid arrives in it.
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_rsp_err;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel       <= w_winner;
            r_rr_ptr    <= w_rr_next;
            r_mem_addr  <= w_addr_arr[w_winner];
            r_mem_wdata <= w_wdata_arr[w_winner];
            r_mem_we    <= i_req_we[w_winner];
            r_mem_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_rsp_rdata <= i_mem_rdata;
            r_rsp_valid <= w_sel_onehot;
            r_state     <= S_DONE;
`ifdef MEM_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_sel_onehot;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt    <= r_to_cnt + CNT_W'(1);
`endif
          end
        end
        S_DONE: begin
          r_rsp_valid <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign o_rsp_err = r_rsp_err;
`else
  // Watchdog compiled out: the error flag is constant and the limit unused.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign o_rsp_err        = 1'b0;
`endif

  assign o_sel       = r_sel;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
//   A behavioural model (round-robin pointer + arithmetic on the transaction
//   timeline) predicts grant, payload, response and latency. Timeout checks
//   are compiled in when MEM_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0]      req_addr;
  logic [N*DW-1:0]      req_wdata;
  logic [DW-1:0]        rsp_rdata, mem_wdata, mem_rdata;
  logic                 rsp_err, mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [$clog2(N)-1:0] sel;
  logic [AW-1:0]        mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_sel(sel), .o_mem_valid(mem_valid), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  int model_rr = 0;

  typedef struct {
    logic [N-1:0]         ready;      // req_ready in the accept cycle
    logic [$clog2(N)-1:0] sel;        // sel in first ISSUE cycle
    logic [AW-1:0]        addr;
    logic [DW-1:0]        wdata;
    logic                 we;
    logic                 mvalid;     // mem_valid in first ISSUE cycle
    bit                   stable;     // ISSUE held steady, mem_valid low in WAIT
    bit                   busy_ready; // any req_ready seen while busy
    int                   lat;        // accept -> rsp_valid cycles (-1: never)
    logic [N-1:0]         rsp;
    logic [DW-1:0]        rdata;
    logic                 err;
    logic [N-1:0]         after_rsp;  // rsp_valid in cycle after DONE
    logic [$clog2(N)-1:0] sel_idle;   // sel back in IDLE
  } obs_t;

  // Reference arbitration: first valid requester upward from the pointer.
  function automatic int model_winner(input logic [N-1:0] v);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      int idx = (model_rr + k) % N;
      t = v >> idx;
      if (t[0]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] rand_wide();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = $urandom;
    return r;
  endfunction

  // Drives one transaction starting in an IDLE cycle (just after a negedge)
  // and records what the DUT did; returns just after the negedge of the
  // IDLE cycle that follows DONE.
  task automatic run_txn(input logic [N-1:0] valid, input logic [N-1:0] we,
                         input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata,
                         input bit hold, input int stall, input int lat,
                         input logic [DW-1:0] rdata, output obs_t o);
    int cycle;
    req_valid = valid; req_we = we; req_addr = addr; req_wdata = wdata;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    #1;
    o.ready = req_ready;
    @(negedge clk); cycle = 1;
    // Payload changes after accept must not leak into the transaction.
    req_addr = rand_wide(); req_wdata = rand_wide(); req_we = N'($urandom);
    if (!hold) req_valid = '0;
    #1;
    o.sel = sel; o.addr = mem_addr; o.wdata = mem_wdata; o.we = mem_we; o.mvalid = mem_valid;
    o.stable = 1'b1; o.busy_ready = 1'b0; o.lat = -1;
    o.rsp = '0; o.rdata = '0; o.err = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) #1;
      o.stable &= (mem_valid === 1'b1) && (mem_addr === o.addr) && (mem_wdata === o.wdata)
                  && (mem_we === o.we) && (sel === o.sel);
      o.busy_ready |= (req_ready !== '0);
      mem_ready  = (s == stall);
      mem_rvalid = (s == stall) ? 1'b0 : 1'($urandom);
      @(negedge clk); cycle++;
    end
    for (int w = 0; w < 150; w++) begin
      #1;
      if (rsp_valid !== '0) begin
        o.lat = cycle; o.rsp = rsp_valid; o.rdata = rsp_rdata; o.err = rsp_err;
        break;
      end
      o.stable &= (mem_valid === 1'b0);
      o.busy_ready |= (req_ready !== '0);
      mem_ready  = 1'($urandom);
      mem_rvalid = (w == lat);
      mem_rdata  = (w == lat) ? rdata : DW'($urandom);
      @(negedge clk); cycle++;
    end
    o.busy_ready |= (req_ready !== '0);
    mem_ready = 1'($urandom); mem_rvalid = 1'($urandom);
    @(negedge clk);
    #1;
    o.after_rsp = rsp_valid; o.sel_idle = sel;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    n_txn++;
    $display("txn %0d: valid=%b grant=%0d we=%0b addr=0x%08h wdata=0x%08h rsp_valid=%b rdata=0x%08h err=%0b lat=%0d",
             n_txn, valid, o.sel, o.we, o.addr, o.wdata, o.rsp, o.rdata, o.err, o.lat);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({sel, mem_valid, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_values got sel=%0d mv=%b we=%b addr=%h wd=%h rv=%b rd=%h err=%b, expected all 0",
               sel, mem_valid, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    req_valid = 2'b10; #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL reset_ready_comb got=%b expected=10", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b01; req_addr = 64'h0000_0000_0000_0055; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL abort_accept got=%b expected=01", req_ready);
    end
    @(negedge clk); req_valid = '0; #1;
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h55) begin
      n_bad++; $display("FAIL abort_issue got mv=%b addr=%h expected mv=1 addr=00000055", mem_valid, mem_addr);
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({sel, mem_valid, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset_values got sel=%0d mv=%b we=%b addr=%h wd=%h rv=%b, expected all 0",
               sel, mem_valid, mem_we, mem_addr, mem_wdata, rsp_valid);
    end
    model_rr = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom; #1;
      n_cmp++;
      if (rsp_valid !== '0 || mem_valid !== 1'b0 || req_ready !== '0) begin
        n_bad++;
        $display("FAIL abort_no_rsp cycle=%0d got rv=%b mv=%b ready=%b expected 0/0/0", c, rsp_valid, mem_valid, req_ready);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    req_valid = 2'b11; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL reset_rr_ptr got=%b expected=01", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single_read;
    obs_t o;
    int   w;
    w = model_winner(2'b10);
    model_rr = (w + 1) % N;
    run_txn(2'b10, 2'b00, {32'h0000_0100, 32'h0}, '0, 1'b0, 0, 0, 32'hDEADBEEF, o);
    n_cmp++;
    if (o.ready !== 2'b10 || o.sel !== 1'b1 || o.addr !== 32'h100 || o.we !== 1'b0 || o.mvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_issue got ready=%b sel=%0d addr=%h we=%b mv=%b expected 10/1/100/0/1",
               o.ready, o.sel, o.addr, o.we, o.mvalid);
    end
    n_cmp++;
    if (o.rsp !== 2'b10 || o.rdata !== 32'hDEADBEEF || o.err !== 1'b0 || o.lat != 3) begin
      n_bad++;
      $display("FAIL single_rsp got rv=%b rd=%h err=%b lat=%0d expected 10/deadbeef/0/3",
               o.rsp, o.rdata, o.err, o.lat);
    end
    n_cmp++;
    if (o.after_rsp !== '0 || o.sel_idle !== 1'b1 || o.busy_ready) begin
      n_bad++;
      $display("FAIL single_after got rv=%b sel=%0d busy_ready=%0b expected 00/1/0", o.after_rsp, o.sel_idle, o.busy_ready);
    end
  endtask

  task automatic test_round_robin;
    obs_t o;
    int   w;
    logic [N-1:0] v;
    for (int t = 0; t < 7; t++) begin
      v = (t < 4) ? 2'b11 : 2'b01;
      w = model_winner(v);
      model_rr = (w + 1) % N;
      run_txn(v, 2'b00, rand_wide(), rand_wide(), 1'b1, 0, 0, 32'h1000 + t, o);
      n_cmp++;
      if (o.sel !== w[0] || o.rsp !== (2'b01 << w) || o.lat != 3) begin
        n_bad++;
        $display("FAIL rr_grant t=%0d got sel=%0d rv=%b lat=%0d expected sel=%0d lat=3", t, o.sel, o.rsp, o.lat, w);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    obs_t o;
    int   w;
    w = model_winner(2'b01);
    model_rr = (w + 1) % N;
    run_txn(2'b01, 2'b00, {32'h0, 32'h0000_0200}, {32'h0, 32'h1234_5678}, 1'b0, 5, 0, 32'hCAFE_0001, o);
    n_cmp++;
    if (!o.stable || o.addr !== 32'h200 || o.wdata !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL bp_stable got stable=%0b addr=%h wdata=%h expected 1/200/12345678", o.stable, o.addr, o.wdata);
    end
    n_cmp++;
    if (o.lat != 8 || o.rsp !== 2'b01 || o.rdata !== 32'hCAFE_0001) begin
      n_bad++;
      $display("FAIL bp_latency got lat=%0d rv=%b rd=%h expected 8/01/cafe0001", o.lat, o.rsp, o.rdata);
    end
  endtask

  task automatic test_write;
    obs_t o;
    int   w;
    w = model_winner(2'b01);
    model_rr = (w + 1) % N;
    run_txn(2'b01, 2'b01, {32'h0, 32'h0000_0040}, {32'h0, 32'hA5A5_A5A5}, 1'b0, 0, 2, 32'h0BAD_F00D, o);
    n_cmp++;
    if (o.we !== 1'b1 || o.wdata !== 32'hA5A5_A5A5 || o.addr !== 32'h40 || o.sel !== 1'b0) begin
      n_bad++;
      $display("FAIL write_issue got we=%b wdata=%h addr=%h sel=%0d expected 1/a5a5a5a5/40/0", o.we, o.wdata, o.addr, o.sel);
    end
    n_cmp++;
    if (o.rsp !== 2'b01 || o.rdata !== 32'h0BAD_F00D || o.lat != 5) begin
      n_bad++;
      $display("FAIL write_ack got rv=%b rd=%h lat=%0d expected 01/0badf00d/5", o.rsp, o.rdata, o.lat);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    int   w;
    w = model_winner(2'b10);
    model_rr = (w + 1) % N;
    run_txn(2'b10, 2'b00, rand_wide(), rand_wide(), 1'b0, 0, 1000, 32'hFFFF_FFFF, o);
    n_cmp++;
    if (o.rsp !== 2'b10 || o.err !== 1'b1 || o.rdata !== '0 || o.lat != TO + 2) begin
      n_bad++;
      $display("FAIL timeout_err got rv=%b err=%b rd=%h lat=%0d expected 10/1/0/%0d", o.rsp, o.err, o.rdata, o.lat, TO + 2);
    end
    w = model_winner(2'b10);
    model_rr = (w + 1) % N;
    run_txn(2'b10, 2'b00, rand_wide(), rand_wide(), 1'b0, 0, TO - 1, 32'h7777_0000, o);
    n_cmp++;
    if (o.err !== 1'b0 || o.rdata !== 32'h7777_0000 || o.lat != TO + 2) begin
      n_bad++;
      $display("FAIL timeout_tie got err=%b rd=%h lat=%0d expected 0/77770000/%0d", o.err, o.rdata, o.lat, TO + 2);
    end
    w = model_winner(2'b11);
    model_rr = (w + 1) % N;
    run_txn(2'b11, 2'b00, rand_wide(), rand_wide(), 1'b0, 0, 0, 32'h0000_1111, o);
    n_cmp++;
    if (o.err !== 1'b0 || o.rdata !== 32'h1111 || o.lat != 3 || o.sel !== w[0]) begin
      n_bad++;
      $display("FAIL timeout_recover got err=%b rd=%h lat=%0d sel=%0d expected 0/1111/3/%0d", o.err, o.rdata, o.lat, o.sel, w);
    end
  endtask
`endif

  task automatic test_random;
    obs_t o;
    int   w, stall, lat, exp_lat;
    logic [N-1:0]    v, we;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [DW-1:0]   rd;
    bit   exp_err;
    for (int t = 0; t < 40; t++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      we = N'($urandom); a = rand_wide(); d = rand_wide(); rd = $urandom;
      stall = $urandom_range(0, 3);
      lat = TO_EN ? $urandom_range(0, TO + 3) : $urandom_range(0, 3);
      w = model_winner(v);
      model_rr = (w + 1) % N;
      exp_err = TO_EN && (lat >= TO);
      exp_lat = exp_err ? stall + 2 + TO : stall + lat + 3;
      run_txn(v, we, a, d, 1'($urandom), stall, lat, rd, o);
      n_cmp++;
      if (o.ready !== (2'b01 << w) || o.sel !== w[0] || o.addr !== a[w*AW +: AW] ||
          o.wdata !== d[w*DW +: DW] || o.we !== we[w] || !o.stable || o.busy_ready) begin
        n_bad++;
        $display("FAIL rand_issue t=%0d got ready=%b sel=%0d addr=%h wd=%h we=%b stable=%0b busy=%0b expected grant %0d addr=%h wd=%h we=%b",
                 t, o.ready, o.sel, o.addr, o.wdata, o.we, o.stable, o.busy_ready, w, a[w*AW +: AW], d[w*DW +: DW], we[w]);
      end
      n_cmp++;
      if (o.rsp !== (2'b01 << w) || o.lat != exp_lat || o.err !== exp_err ||
          o.rdata !== (exp_err ? '0 : rd) || o.after_rsp !== '0 || o.sel_idle !== w[0]) begin
        n_bad++;
        $display("FAIL rand_rsp t=%0d got rv=%b lat=%0d err=%b rd=%h after=%b sel=%0d expected lat=%0d err=%0b rd=%h",
                 t, o.rsp, o.lat, o.err, o.rdata, o.after_rsp, o.sel_idle, exp_lat, exp_err, exp_err ? '0 : rd);
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        @(negedge clk); #1;
      end
    end
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_single_read;
    test_round_robin;
    test_backpressure;
    test_write;
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
